uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver byte stream and the on-chip register file.
- Parses framed read/write commands, checks a checksum and issues single-cycle register strobes.
- Queues a response byte stream toward the UART transmitter over a valid/ready handshake.
- Enforces an inter-byte timeout and keeps a saturating error count for debug and LED status.

Parameters:
- SYNC, 8'h55, frame start byte.
- ACK, 8'hAA, response byte for a successful command.
- NAK, 8'hEE, response byte for a checksum failure.
- TIMEOUT, 8700, max clk_10 cycles between bytes inside a frame (~10 byte times at 115200 baud, 10 MHz).

Ports:
- clk_10  in  1  system clock, 10 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe, new byte on rx_data
- rx_error  in  1  one-cycle strobe, framing error from the receiver
- reg_addr  out  7  register address, held from CMD until IDLE
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_re
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in every state except IDLE
- err_count  out  8  saturating error counter

Behaviour:
- Interface: one clock, clk_10; reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, timeout counter 0, err_count 0.
- Reset mid-frame or mid-response discards all progress; no strobe and no tx byte is emitted afterwards.
- Frame format: SYNC, CMD, [DATA if CMD[7]=1], CSUM.
  - CMD[7]: 1 = write, 0 = read. CMD[6:0] = address.
  - CSUM = (SYNC + CMD [+ DATA]) mod 256.
- States: IDLE, CMD, DATA, CSUM, EXEC, RDWAIT, RESP0, RESP1.
  - IDLE: rx_valid with rx_data==SYNC -> CMD, sum<=SYNC. Other bytes are discarded silently; err_count is unchanged.
  - CMD: on byte, latch reg_addr<=CMD[6:0] and the write flag, sum+=byte. -> DATA if write, else -> CSUM.
  - DATA: on byte, reg_wdata<=byte, sum+=byte -> CSUM.
  - CSUM: on byte, if byte==sum -> EXEC. Otherwise load tx_data=NAK, tx_valid=1, err_count++ -> RESP1.
  - EXEC: one cycle.
    - Write: reg_we=1, then tx_data=ACK -> RESP1.
    - Read: reg_re=1 -> RDWAIT.
  - RDWAIT: capture reg_rdata into a holding register; tx_data=ACK, tx_valid=1 -> RESP0.
  - RESP0: on tx_valid&tx_ready, tx_data<=held rdata, tx_valid stays 1 -> RESP1.
  - RESP1: on tx_valid&tx_ready, tx_valid<=0 -> IDLE.
- tx handshake: tx_data is stable while tx_valid=1 and tx_ready=0. Transfer occurs on the cycle where both are high. No combinational path from tx_ready to tx_valid.
- Latency: the EXEC strobe fires 1 cycle after the CSUM byte's rx_valid. For a read with tx_ready tied high, the ACK is presented 2 cycles after reg_re.
- Timeout:
  - The counter runs in CMD, DATA and CSUM, and clears on every rx_valid and on entry to CMD.
  - At count==TIMEOUT-1 without rx_valid: -> IDLE, err_count++, no tx.
  - rx_valid on the expiry cycle: the byte wins and no timeout is flagged.
- rx_error:
  - In CMD/DATA/CSUM: -> IDLE, err_count++.
  - In IDLE: err_count++ only.
  - Simultaneous rx_valid and rx_error: the byte is treated as error and discarded.
- Bytes arriving in EXEC, RDWAIT, RESP0 or RESP1 are dropped, with err_count++ per byte. Parsing never overlaps a response.
- err_count saturates at 8'hFF. Multiple error sources in one cycle count as 1.
- reg_we and reg_re are never high together, and are never high outside EXEC.

Test Plan:
- Read: bytes 55,3F,94 at 870-cycle spacing, reg_rdata=A5, tx_ready=1 -> reg_re one pulse with reg_addr=3F; tx sequence AA then A5; busy drops after the final handshake; err_count=0.
- Write: bytes 55,81,12,E8 -> reg_we one pulse with reg_addr=01 and reg_wdata=12; tx AA only; reg_re never asserts.
- Bad checksum: 55,3F,00 -> no strobes; tx EE; err_count=1. A following valid read frame completes normally.
- Timeout: 55, then idle for TIMEOUT cycles -> back in IDLE, err_count=1, no tx. Variant: a byte on exactly the expiry cycle is accepted with no error.
- Robustness:
  - Garbage byte 00 in IDLE -> ignored, err_count unchanged.
  - rx_error after CMD -> IDLE, err_count++.
  - tx_ready held low 50 cycles during a read response -> tx_data=AA stable, tx_valid=1 throughout.
  - A byte received during RESP0 -> dropped, err_count++.
- Reset: assert rst for 1 cycle after 55,3F -> all outputs 0, err_count 0. A subsequent CSUM byte 94 alone produces no strobe and no tx.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
`timescale 1ns/1ps
// uart_cmd_ctrl
// Command sequencer sitting between a UART receiver byte stream and an
// on-chip register file. Parses frames of the form
//   SYNC, CMD, [DATA when CMD[7]=1], CSUM     (CSUM = byte sum mod 256)
// issues one-cycle register read/write strobes, and returns ACK (+ read
// data) or NAK to the UART transmitter over a valid/ready handshake.
// An inter-byte timeout aborts stalled frames; a saturating error counter
// records checksum failures, timeouts, framing errors and dropped bytes.
//
// Ports:
//   clk_10     in   system clock (10 MHz)
//   rst        in   synchronous active-high reset
//   rx_data    in   [7:0] received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe, new byte
//   rx_error   in   one-cycle strobe, receiver framing error
//   reg_addr   out  [6:0] register address, latched from CMD
//   reg_wdata  out  [7:0] write data, latched from DATA
//   reg_we     out  one-cycle write strobe
//   reg_re     out  one-cycle read strobe
//   reg_rdata  in   [7:0] read data, valid the cycle after reg_re
//   tx_data    out  [7:0] response byte
//   tx_valid   out  response byte valid
//   tx_ready   in   transmitter accepts byte
//   busy       out  high whenever the sequencer is not idle
//   err_count  out  [7:0] saturating error counter
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter logic [7:0]  ACK     = 8'hAA,
  parameter logic [7:0]  NAK     = 8'hEE,
  parameter int unsigned TIMEOUT = 8700
) (
  input  logic       clk_10,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_EXEC   = 3'd4,
    S_RDWAIT = 3'd5,
    S_RESP0  = 3'd6,
    S_RESP1  = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       sum_r, sum_s;
  logic             write_r, write_s;
  logic [7:0]       hold_r, hold_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [6:0]       addr_s;
  logic [7:0]       wdata_s;
  logic             we_s, re_s;
  logic [7:0]       tx_data_s;
  logic             tx_valid_s;
  logic             err_evt_s;
  logic             tx_fire_s;

  assign tx_fire_s = tx_valid & tx_ready;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s    = state_r;
    sum_s      = sum_r;
    write_s    = write_r;
    hold_s     = hold_r;
    cnt_s      = cnt_r;
    addr_s     = reg_addr;
    wdata_s    = reg_wdata;
    we_s       = 1'b0;
    re_s       = 1'b0;
    tx_data_s  = tx_data;
    tx_valid_s = tx_valid;
    err_evt_s  = 1'b0;

    case (state_r)
      S_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        // A framing error wins over a coincident byte, even a SYNC.
        if (rx_error) begin
          err_evt_s = 1'b1;
        end else if (rx_valid && (rx_data == SYNC)) begin
          state_s = S_CMD;
          sum_s   = SYNC;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_CMD, S_DATA, S_CSUM: begin
        if (rx_error) begin
          state_s   = S_IDLE;
          err_evt_s = 1'b1;
          cnt_s     = {CNT_W{1'b0}};
        end else if (rx_valid) begin
          // A byte on the expiry cycle is checked first, so it wins.
          cnt_s = {CNT_W{1'b0}};
          sum_s = sum_r + rx_data;
          case (state_r)
            S_CMD: begin
              addr_s  = rx_data[6:0];
              write_s = rx_data[7];
              state_s = rx_data[7] ? S_DATA : S_CSUM;
            end
            S_DATA: begin
              wdata_s = rx_data;
              state_s = S_CSUM;
            end
            default: begin
              if (rx_data == sum_r) begin
                state_s = S_EXEC;
                we_s    = write_r;
                re_s    = ~write_r;
              end else begin
                tx_data_s  = NAK;
                tx_valid_s = 1'b1;
                err_evt_s  = 1'b1;
                state_s    = S_RESP1;
              end
            end
          endcase
        end else if (cnt_r == CNT_LAST) begin
          state_s   = S_IDLE;
          err_evt_s = 1'b1;
          cnt_s     = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      S_EXEC: begin
        err_evt_s = rx_valid | rx_error;
        if (write_r) begin
          tx_data_s  = ACK;
          tx_valid_s = 1'b1;
          state_s    = S_RESP1;
        end else begin
          state_s = S_RDWAIT;
        end
      end

      S_RDWAIT: begin
        // reg_rdata is valid now; keep it until ACK has been accepted.
        err_evt_s  = rx_valid | rx_error;
        hold_s     = reg_rdata;
        tx_data_s  = ACK;
        tx_valid_s = 1'b1;
        state_s    = S_RESP0;
      end

      S_RESP0: begin
        err_evt_s = rx_valid | rx_error;
        if (tx_fire_s) begin
          tx_data_s = hold_r;
          state_s   = S_RESP1;
        end else begin
          state_s = S_RESP0;
        end
      end

      S_RESP1: begin
        err_evt_s = rx_valid | rx_error;
        if (tx_fire_s) begin
          tx_valid_s = 1'b0;
          state_s    = S_IDLE;
        end else begin
          state_s = S_RESP1;
        end
      end

      default: begin
        state_s    = S_IDLE;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_10) begin
    if (rst) begin
      state_r   <= S_IDLE;
      sum_r     <= 8'h00;
      write_r   <= 1'b0;
      hold_r    <= 8'h00;
      cnt_r     <= {CNT_W{1'b0}};
      reg_addr  <= 7'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      sum_r     <= sum_s;
      write_r   <= write_s;
      hold_r    <= hold_s;
      cnt_r     <= cnt_s;
      reg_addr  <= addr_s;
      reg_wdata <= wdata_s;
      reg_we    <= we_s;
      reg_re    <= re_s;
      tx_data   <= tx_data_s;
      tx_valid  <= tx_valid_s;
      busy      <= (state_s != S_IDLE);
    end
  end

  // Saturating error counter; simultaneous sources count once.
  always_ff @(posedge clk_10) begin
    if (rst) begin
      err_count <= 8'h00;
    end else if (err_evt_s && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
// Testbench for uart_cmd_ctrl: directed frames, expected tx bytes and
// register strobes are queued as stimulus is issued; a monitor on the
// falling edge pops and compares them whenever the DUT presents them.
module tb_uart_cmd_ctrl;

  logic       clk_10 = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [7:0] err_count;

  logic [7:0] rdata_val;
  assign reg_rdata = rdata_val;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
  } strobe_t;

  logic [7:0] txq[$];
  strobe_t    stq[$];
  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  uart_cmd_ctrl dut (
    .clk_10    (clk_10),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .err_count (err_count)
  );

  initial forever #50 clk_10 = ~clk_10;

  initial begin
    #6_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Falling-edge monitor: tx transfers and register strobes.
  initial begin
    logic [7:0] e;
    strobe_t    s;
    forever begin
      @(negedge clk_10);
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %0h, expected no byte", tx_data);
        end else begin
          e = txq.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
      end
      if (reg_we || reg_re) begin
        chk("strobe_exclusive", 32'(reg_we & reg_re), 32'd0);
        if (stq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected: got we=%0b re=%0b, expected none", reg_we, reg_re);
        end else begin
          s = stq.pop_front();
          chk("strobe_kind_we", 32'(reg_we), 32'(s.we));
          chk("strobe_addr", 32'(reg_addr), 32'(s.addr));
          if (s.we) chk("strobe_wdata", 32'(reg_wdata), 32'(s.wdata));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_10);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_error();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
  endtask

  task automatic exp_read(input logic [6:0] a, input logic [7:0] d);
    strobe_t s;
    s = '{we: 1'b0, addr: a, wdata: 8'h00};
    stq.push_back(s);
    txq.push_back(8'hAA);
    txq.push_back(d);
  endtask

  task automatic frame3(input logic [7:0] b1, input logic [7:0] b2, input int gap);
    send_byte(8'h55);
    idle(gap);
    send_byte(b1);
    idle(gap);
    send_byte(b2);
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (txq.size() == 0 && stq.size() == 0 && !busy) break;
      tick();
    end
    chk(name, 32'(txq.size() == 0 && stq.size() == 0 && busy == 1'b0), 32'd1);
  endtask

  initial begin
    strobe_t s;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    tx_ready = 1'b1; rdata_val = 8'hA5;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_strobes", 32'({reg_we, reg_re}), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Read at 870-cycle spacing with latency checks.
    exp_read(7'h3F, 8'hA5);
    frame3(8'h3F, 8'h94, 869);
    chk("rd_exec_re", 32'(reg_re), 32'd1);
    chk("rd_exec_addr", 32'(reg_addr), 32'h3F);
    tick();
    chk("rd_rdwait_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("rd_ack_valid", 32'(tx_valid), 32'd1);
    chk("rd_ack_data", 32'(tx_data), 32'hAA);
    drain("rd_drain", 20);
    chk("rd_err", 32'(err_count), 32'(exp_err));

    // Write 55,81,12,E8.
    s = '{we: 1'b1, addr: 7'h01, wdata: 8'h12};
    stq.push_back(s);
    txq.push_back(8'hAA);
    send_byte(8'h55); idle(3);
    send_byte(8'h81); idle(3);
    send_byte(8'h12); idle(3);
    send_byte(8'hE8);
    drain("wr_drain", 20);
    chk("wr_err", 32'(err_count), 32'(exp_err));

    // Bad checksum then a valid read.
    txq.push_back(8'hEE);
    frame3(8'h3F, 8'h00, 3);
    drain("nak_drain", 20);
    exp_err = 1;
    chk("nak_err", 32'(err_count), 32'(exp_err));
    exp_read(7'h3F, 8'hA5);
    frame3(8'h3F, 8'h94, 3);
    drain("after_nak_drain", 20);
    chk("after_nak_err", 32'(err_count), 32'(exp_err));

    // Garbage byte in IDLE is ignored silently.
    send_byte(8'h00);
    idle(5);
    chk("garbage_busy", 32'(busy), 32'd0);
    chk("garbage_err", 32'(err_count), 32'(exp_err));

    // rx_error after CMD aborts the frame.
    send_byte(8'h55); idle(2);
    send_byte(8'h3F); idle(2);
    pulse_error();
    exp_err = 2;
    chk("rxerr_busy", 32'(busy), 32'd0);
    chk("rxerr_err", 32'(err_count), 32'(exp_err));

    // Timeout: busy through the expiry cycle, IDLE right after.
    send_byte(8'h55);
    idle(8699);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    tick();
    exp_err = 3;
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_err", 32'(err_count), 32'(exp_err));

    // Byte exactly on the expiry cycle is accepted.
    exp_read(7'h3F, 8'hA5);
    send_byte(8'h55);
    idle(8699);
    send_byte(8'h3F);
    idle(2);
    send_byte(8'h94);
    drain("expiry_drain", 20);
    chk("expiry_err", 32'(err_count), 32'(exp_err));

    // Stalled transmitter, then a dropped byte during RESP0.
    tx_ready = 1'b0;
    rdata_val = 8'h5A;
    exp_read(7'h3F, 8'h5A);
    frame3(8'h3F, 8'h94, 2);
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) break;
      tick();
    end
    chk("stall_valid_seen", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'hAA);
    end
    rdata_val = 8'h00;
    send_byte(8'h77);
    exp_err = 4;
    chk("resp0_drop_err", 32'(err_count), 32'(exp_err));
    chk("resp0_drop_data", 32'(tx_data), 32'hAA);
    tx_ready = 1'b1;
    drain("stall_drain", 20);
    chk("stall_err", 32'(err_count), 32'(exp_err));

    // Reset mid-frame discards all progress.
    send_byte(8'h55); idle(2);
    send_byte(8'h3F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_err", 32'(err_count), 32'd0);
    chk("mrst_addr", 32'(reg_addr), 32'd0);
    chk("mrst_wdata", 32'(reg_wdata), 32'd0);
    chk("mrst_tx", 32'({tx_valid, tx_data}), 32'd0);
    chk("mrst_strobes", 32'({reg_we, reg_re}), 32'd0);
    send_byte(8'h94);
    idle(10);
    drain("mrst_drain", 5);
    chk("mrst_err_after", 32'(err_count), 32'd0);

    // SYNC with coincident rx_error is treated as an error.
    rx_data = 8'h55; rx_valid = 1'b1; rx_error = 1'b1;
    tick();
    rx_valid = 1'b0; rx_error = 1'b0;
    exp_err = 1;
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_err", 32'(err_count), 32'(exp_err));

    // Saturation at FF.
    for (int i = 0; i < 300; i++) pulse_error();
    chk("sat_err", 32'(err_count), 32'hFF);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
